// File: rtl/apu_resp_pkg.sv
// Shared response type and DEPTH bounds for the APU response buffer.
package apu_resp_pkg;

  localparam int RESP_ID_W    = 9;
  localparam int RESP_DATA_W  = 32;
  localparam int RESP_FLAGS_W = 5;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  typedef struct packed {
    logic [RESP_DATA_W-1:0]  data;
    logic [RESP_FLAGS_W-1:0] flags;
    logic [RESP_ID_W-1:0]    id;
  } resp_t;

endpackage

// File: rtl/apu_resp_fifo.sv
// In-order response storage with modulo-DEPTH pointers (any DEPTH >= 2).
module apu_resp_fifo #(
  parameter int WIDTH = 46,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wrap_inc(wptr);
      if (pop)  rptr <= wrap_inc(rptr);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  assign rdata = mem[rptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && full && !pop)) else $error("apu_resp_fifo: push while full");
      assert (!(pop && empty)) else $error("apu_resp_fifo: pop while empty");
    end
  end

endmodule

// File: rtl/apu_resp_buffer.sv
// Credit-gated APU request path with in-order response FIFO.
// Optional same-cycle bypass when compiled with APU_RESP_BUFFER_BYPASS_EN.
module apu_resp_buffer
  import apu_resp_pkg::*;
#(
  parameter int ID_WIDTH        = 9,
  parameter int DATA_WIDTH      = 32,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int DEPTH           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       apu_req_i,
  output logic                       apu_gnt_o,
  output logic                       fpu_req_o,
  input  logic                       fpu_gnt_i,
  input  logic                       fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]      fpu_rdata_i,
  input  logic [FLAGS_OUT_WIDTH-1:0] fpu_rflags_i,
  input  logic [ID_WIDTH-1:0]        fpu_rID_i,
  output logic                       apu_rvalid_o,
  input  logic                       apu_rready_i,
  output logic [DATA_WIDTH-1:0]      apu_rdata_o,
  output logic [FLAGS_OUT_WIDTH-1:0] apu_rflags_o,
  output logic [ID_WIDTH-1:0]        apu_rID_o,
  output logic [$clog2(DEPTH+1)-1:0] credits_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;

  logic [CW-1:0] credits;
  logic          credit_avail;
  logic          issue;
  logic          pop;
  logic          bypass;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [RW-1:0] wdata;
  logic [RW-1:0] head;
  logic [RW-1:0] resp_out;

  assign credit_avail = (credits != '0);
  assign fpu_req_o    = apu_req_i & credit_avail;
  assign apu_gnt_o    = fpu_gnt_i & credit_avail;
  assign issue        = apu_req_i & apu_gnt_o;
  assign pop          = apu_rvalid_o & apu_rready_i;

  assign wdata = {fpu_rdata_i, fpu_rflags_i, fpu_rID_i};

`ifdef APU_RESP_BUFFER_BYPASS_EN
  assign bypass = fifo_empty & fpu_rvalid_i & apu_rready_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response is consumed straight from the FPU, so the FIFO only pops real entries.
  assign fifo_push = fpu_rvalid_i & ~bypass;
  assign fifo_pop  = pop & ~fifo_empty;

  apu_resp_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wdata),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    apu_rvalid_o = ~fifo_empty;
    resp_out     = fifo_empty ? '0 : head;
`ifdef APU_RESP_BUFFER_BYPASS_EN
    if (bypass) begin
      apu_rvalid_o = 1'b1;
      resp_out     = wdata;
    end
`endif
  end

  assign {apu_rdata_o, apu_rflags_o, apu_rID_o} = resp_out;
  assign credits_o = credits;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits <= CW'(DEPTH);
    end else if (issue && !pop) begin
      credits <= credits - CW'(1);
    end else if (pop && !issue) begin
      credits <= credits + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (DEPTH >= DEPTH_MIN && DEPTH <= DEPTH_MAX) else $error("apu_resp_buffer: DEPTH out of range");
      assert (!(pop && !issue && credits == CW'(DEPTH))) else $error("apu_resp_buffer: credit overflow");
      assert (int'(fifo_count) + int'(credits) <= DEPTH) else $error("apu_resp_buffer: occupancy exceeds credit pool");
      assert (!(fifo_push && fifo_full && !fifo_pop)) else $error("apu_resp_buffer: response overflow");
    end
  end

endmodule

// File: tb/tb_apu_resp_buffer.sv
// Randomized scoreboard bench for apu_resp_buffer (DEPTH=4), default or bypass build.
module tb_apu_resp_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  f;
    logic [8:0]  id;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        apu_req_i;
  logic        apu_gnt_o;
  logic        fpu_req_o;
  logic        fpu_gnt_i;
  logic        fpu_rvalid_i;
  logic [31:0] fpu_rdata_i;
  logic [4:0]  fpu_rflags_i;
  logic [8:0]  fpu_rID_i;
  logic        apu_rvalid_o;
  logic        apu_rready_i;
  logic [31:0] apu_rdata_o;
  logic [4:0]  apu_rflags_o;
  logic [8:0]  apu_rID_o;
  logic [2:0]  credits_o;

  apu_resp_buffer #(
    .ID_WIDTH(9), .DATA_WIDTH(32), .FLAGS_OUT_WIDTH(5), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
    .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
    .fpu_rvalid_i(fpu_rvalid_i), .fpu_rdata_i(fpu_rdata_i),
    .fpu_rflags_i(fpu_rflags_i), .fpu_rID_i(fpu_rID_i),
    .apu_rvalid_o(apu_rvalid_o), .apu_rready_i(apu_rready_i),
    .apu_rdata_o(apu_rdata_o), .apu_rflags_o(apu_rflags_o),
    .apu_rID_o(apu_rID_o), .credits_o(credits_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   inflight = 0;
  int   outstanding = 0;
  bit   pushed_now = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Drive one cycle of stimulus just after the edge; return at the following negedge.
  task automatic drive(input logic req, input logic gnt, input logic rv, input logic rdy,
                       input logic rstv, input logic [8:0] id, input logic [31:0] data);
    @(posedge clk);
    #1;
    apu_req_i    = req;
    fpu_gnt_i    = gnt;
    apu_rready_i = rdy;
    rst_n        = rstv;
    if (rv && rstv && inflight > 0) begin
      exp_t e;
      e.d = data;
      e.f = 5'($urandom);
      e.id = id;
      fpu_rvalid_i = 1'b1;
      fpu_rdata_i  = e.d;
      fpu_rflags_i = e.f;
      fpu_rID_i    = e.id;
      exp_q.push_back(e);
      pushed_now = 1'b1;
      inflight--;
    end else begin
      fpu_rvalid_i = 1'b0;
      fpu_rdata_i  = 32'($urandom);
      fpu_rflags_i = 5'($urandom);
      fpu_rID_i    = 9'($urandom);
      pushed_now   = 1'b0;
    end
    @(negedge clk);
    if (!rstv) inflight = 0;
    else if (apu_req_i && apu_gnt_o) inflight++;
  endtask

  // Monitor: reference credit pool = DEPTH - (issued - returned); responses in push order.
  int mc;
  int nb;
  bit exp_v;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      outstanding = 0;
    end else begin
      mc = DEPTH - outstanding;
      chk("credits", 64'(credits_o), 64'(mc));
      chk("apu_gnt", 64'(apu_gnt_o), 64'(fpu_gnt_i && mc != 0));
      chk("fpu_req", 64'(fpu_req_o), 64'(apu_req_i && mc != 0));
      nb = exp_q.size() - int'(pushed_now);
`ifdef APU_RESP_BUFFER_BYPASS_EN
      exp_v = (nb > 0) || (fpu_rvalid_i && apu_rready_i);
`else
      exp_v = (nb > 0);
`endif
      chk("apu_rvalid", 64'(apu_rvalid_o), 64'(exp_v));
      if (apu_rvalid_o && exp_q.size() > 0) begin
        chk("rdata", 64'(apu_rdata_o), 64'(exp_q[0].d));
        chk("rflags", 64'(apu_rflags_o), 64'(exp_q[0].f));
        chk("rID", 64'(apu_rID_o), 64'(exp_q[0].id));
        if (apu_rready_i) begin
          void'(exp_q.pop_front());
          outstanding--;
        end
      end
      if (apu_req_i && apu_gnt_o) outstanding++;
    end
  end

  int gcount;

  initial begin
    rst_n = 1'b0; apu_req_i = 1'b0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b0;
    fpu_rdata_i = '0; fpu_rflags_i = '0; fpu_rID_i = '0; apu_rready_i = 1'b0;

    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("reset_credits", 64'(credits_o), 64'(DEPTH));
    chk("reset_rvalid", 64'(apu_rvalid_o), 64'd0);
    chk("reset_rdata", 64'(apu_rdata_o), 64'd0);

    // Back-to-back issues with no consumer: exactly DEPTH grants.
    gcount = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 1, 0, 0);
      if (apu_gnt_o) gcount++;
    end
    chk("grant_count", 64'(gcount), 64'd4);
    chk("fifth_gnt", 64'(apu_gnt_o), 64'd0);
    chk("fifth_fpu_req", 64'(fpu_req_o), 64'd0);
    chk("fifth_credits", 64'(credits_o), 64'd0);

    // Results 3,7,1 then 5, filling the FIFO.
    drive(1, 1, 1, 0, 1, 9'd3, 32'($urandom));
    drive(1, 1, 1, 0, 1, 9'd7, 32'($urandom));
    chk("head_holds_3", 64'(apu_rID_o), 64'd3);
    drive(1, 1, 1, 0, 1, 9'd1, 32'($urandom));
    drive(1, 1, 1, 0, 1, 9'd5, 32'($urandom));

    // Full FIFO: pop and request in the same cycle.
    drive(1, 1, 0, 1, 1, 0, 0);
    chk("popfull_gnt", 64'(apu_gnt_o), 64'd0);
    chk("popfull_credits", 64'(credits_o), 64'd0);
    drive(1, 1, 0, 0, 1, 0, 0);
    chk("after_pop_head", 64'(apu_rID_o), 64'd7);
    chk("after_pop_credits", 64'(credits_o), 64'd1);
    chk("after_pop_gnt", 64'(apu_gnt_o), 64'd1);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("credit_consumed", 64'(credits_o), 64'd0);

    // One reset cycle with three entries buffered.
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("rst_mid_rvalid", 64'(apu_rvalid_o), 64'd0);
    chk("rst_mid_credits", 64'(credits_o), 64'd4);
    chk("rst_mid_rdata", 64'(apu_rdata_o), 64'd0);

    // Latency of a response into an empty FIFO with the consumer ready.
    drive(1, 1, 0, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 1, 9'h2A, 32'h3F800000);
`ifdef APU_RESP_BUFFER_BYPASS_EN
    chk("bypass_rvalid", 64'(apu_rvalid_o), 64'd1);
    chk("bypass_rdata", 64'(apu_rdata_o), 64'h3F800000);
    chk("bypass_credit_ret", 64'(credits_o), 64'd3);
    drive(0, 0, 0, 1, 1, 0, 0);
    chk("bypass_fifo_empty", 64'(apu_rvalid_o), 64'd0);
    chk("bypass_credits", 64'(credits_o), 64'd4);
`else
    chk("nobypass_rvalid0", 64'(apu_rvalid_o), 64'd0);
    drive(0, 0, 0, 1, 1, 0, 0);
    chk("nobypass_rvalid1", 64'(apu_rvalid_o), 64'd1);
    chk("nobypass_rdata", 64'(apu_rdata_o), 64'h3F800000);
    drive(0, 0, 0, 1, 1, 0, 0);
    chk("nobypass_credits", 64'(credits_o), 64'd4);
`endif

    // Randomized traffic with alternating consumer pressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      logic rstv;
      rdy  = ((i % 400) < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rstv = ($urandom_range(0, 199) != 0);
      drive(1'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0), rdy, rstv,
            9'($urandom), 32'($urandom));
    end

    for (int i = 0; i < 30; i++) drive(0, 0, 1, 1, 1, 9'($urandom), 32'($urandom));
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("drain_credits", 64'(credits_o), 64'(DEPTH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apu_resp_buffer.md
APU_RESP_BUFFER -- requirements
Module: apu_resp_buffer

Interface
REQ-001 Parameter ID_WIDTH, default 9, tag width of request and response.
REQ-002 Parameter DATA_WIDTH, default 32, result width.
REQ-003 Parameter FLAGS_OUT_WIDTH, default 5, status-flag width.
REQ-004 Parameter DEPTH, default 4, response FIFO entries and credit pool size; legal range 2..16.
REQ-005 One clock and one synchronous active-low reset: clk (in, 1, rising-edge clock) and rst_n (in, 1, synchronous, active-low).
REQ-006 apu_req_i  in  1  request from the interconnect.
REQ-007 apu_gnt_o  out  1  grant to the interconnect.
REQ-008 fpu_req_o  out  1  request to the FPU wrapper.
REQ-009 fpu_gnt_i  in  1  grant from the FPU wrapper.
REQ-010 fpu_rvalid_i  in  1  FPU result valid, unstallable because the FPU output ready is tied high.
REQ-011 fpu_rdata_i / fpu_rflags_i / fpu_rID_i  in  DATA_WIDTH / FLAGS_OUT_WIDTH / ID_WIDTH  FPU result, status flags and tag.
REQ-012 apu_rvalid_o  out  1  buffered response valid.
REQ-013 apu_rready_i  in  1  consumer ready.
REQ-014 apu_rdata_o / apu_rflags_o / apu_rID_o  out  DATA_WIDTH / FLAGS_OUT_WIDTH / ID_WIDTH  buffered response.
REQ-015 credits_o  out  $clog2(DEPTH+1)  free credits, for debug and performance counters.

Function
REQ-016 The credit counter SHALL start at DEPTH; credit_avail = (credits != 0).
REQ-017 fpu_req_o SHALL equal apu_req_i & credit_avail, and apu_gnt_o SHALL equal fpu_gnt_i & credit_avail, both combinationally.
REQ-018 Issue (apu_req_i & apu_gnt_o) SHALL decrement credits; pop (apu_rvalid_o & apu_rready_i) SHALL increment credits.
REQ-019 Simultaneous issue and pop SHALL leave credits unchanged.
REQ-020 Credits SHALL never go below 0 or above DEPTH.
REQ-021 Every fpu_rvalid_i cycle SHALL push {rdata, rflags, rID} into the FIFO, except in the bypass case (REQ-030).
REQ-022 The FIFO SHALL be in-order; the head drives the apu_r* outputs, with apu_rvalid_o = !empty.
REQ-023 Head outputs SHALL hold stable while apu_rvalid_o=1 and apu_rready_i=0.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged, including when the FIFO is full; when empty with no bypass, push only.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; non-power-of-two DEPTH SHALL be supported.
REQ-026 Invariant: occupancy + in-flight <= DEPTH, so overflow is impossible; a push while full with no pop is a protocol error flagged by assertion.
REQ-027 Minimum latency from fpu_rvalid_i to apu_rvalid_o SHALL be 1 cycle when bypass is compiled out.

Reset
REQ-028 While rst_n=0 at a clk edge: credits=DEPTH, FIFO empty, pointers 0, apu_rvalid_o=0, apu_r* data outputs 0.
REQ-029 A reset during operation SHALL discard buffered entries and restore all credits; FPU results arriving in the reset cycle SHALL be dropped.

Configuration
REQ-030 With macro APU_RESP_BUFFER_BYPASS_EN defined: when the FIFO is empty, fpu_rvalid_i=1 and apu_rready_i=1, the response SHALL pass combinationally to apu_r* outputs, not be pushed, and return its credit in the same cycle (0-cycle latency).
REQ-031 Without the macro: there SHALL be no combinational path from fpu_r* to apu_r*, and all responses SHALL go through the FIFO.

Structure
REQ-032 Package apu_resp_pkg SHALL hold the resp_t typedef (data, flags, id) parameterised via localparams, plus the DEPTH bounds constants.
REQ-033 Sub-module apu_resp_fifo SHALL implement the storage (push, pop, full, empty, count); credit logic, handshake gating and bypass SHALL live in the top.

Verification
REQ-034 Back-to-back issues with DEPTH=4 and apu_rready_i=0 -> exactly 4 grants, 5th apu_req_i sees apu_gnt_o=0 and fpu_req_o=0, credits_o=0.
REQ-035 Results with IDs 3,7,1 on consecutive cycles -> apu_rID_o presents 3,7,1 in order; data and flags match each pushed value.
REQ-036 FIFO full with a pop and an apu_req_i in the same cycle -> credits_o unchanged at 0, then grant issued and credit consumed on the following cycle.
REQ-037 rst_n=0 for one cycle with 3 entries buffered -> next cycle apu_rvalid_o=0, credits_o=4.
REQ-038 APU_RESP_BUFFER_BYPASS_EN set, FIFO empty, fpu_rvalid_i=1 with rdata 32'h3F800000 and apu_rready_i=1 -> same-cycle apu_rvalid_o=1, apu_rdata_o=32'h3F800000, FIFO stays empty; macro unset -> response appears the next cycle.
